fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline; sits directly upstream of the instruction memory.

---
 rtl/mips_pkg.sv | 12 +
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Types and constants shared across the MIPS pipeline stages.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear (bubble) wins over enable; reset loads a bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        valid_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_plus4_q,
  output logic        valid_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (clr) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (en) begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, RUN/HALT control and IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int          IMEM_AW   = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rd_i,
  output logic [31:0]        if_id_instr_o,
  output logic [31:0]        if_id_pc_plus4_o,
  output logic               if_id_valid_o,
  output logic [31:0]        pc_o,
  output logic               halted_o,
  output logic               fault_o
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         fault_reg, fault_next;
  logic         ifid_en, ifid_clr;
  logic [31:0]  pc_plus4;
  logic         out_of_range;

  assign pc_plus4     = pc_reg + 32'd4;
  // Any set bit above the word index means the PC is past the end of the ROM.
  assign out_of_range = |pc_reg[31:IMEM_AW+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
          ifid_clr   = 1'b1;
          fault_next = 1'b1;
          state_next = HALT;
        end else if (redirect_i) begin
          ifid_clr = 1'b1;
          pc_next  = redirect_pc_i;
        end else if (flush_i) begin
          ifid_clr = 1'b1;
          if (!stall_i) pc_next = pc_plus4;
        end else if (stall_i) begin
          ifid_en = 1'b0;
        end else if (out_of_range) begin
          ifid_clr   = 1'b1;
          fault_next = 1'b1;
          state_next = HALT;
        end else if (imem_rd_i == HALT_WORD) begin
          // The halt word itself is never handed to decode.
          ifid_clr   = 1'b1;
          state_next = HALT;
        end else begin
          ifid_en = 1'b1;
          pc_next = pc_plus4;
        end
      end
      HALT: begin
        ifid_clr = 1'b1;
      end
      default: begin
        ifid_clr = 1'b1;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ifid_en),
    .clr        (ifid_clr),
    .instr_d    (imem_rd_i),
    .pc_plus4_d (pc_plus4),
    .valid_d    (1'b1),
    .instr_q    (if_id_instr_o),
    .pc_plus4_q (if_id_pc_plus4_o),
    .valid_q    (if_id_valid_o)
  );

  assign imem_addr_o = pc_reg[IMEM_AW+1:2];
  assign pc_o        = pc_reg;
  assign halted_o    = (state_reg == HALT);
  assign fault_o     = fault_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a behavioural fetch model and ROM array.
module tb_fetch_stage;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr, pp4, pc;
  logic        valid, halted, fault;

  logic [31:0] rom [64];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_halt, m_fault;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign imem_rd = rom[imem_addr];

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_rd_i        (imem_rd),
    .if_id_instr_o    (instr),
    .if_id_pc_plus4_o (pp4),
    .if_id_valid_o    (valid),
    .pc_o             (pc),
    .halted_o         (halted),
    .fault_o          (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},     pc,                 m_pc);
    chk({tag, ".addr"},   {26'h0, imem_addr}, (m_pc / 4) % 64);
    chk({tag, ".instr"},  instr,              m_instr);
    chk({tag, ".pp4"},    pp4,                m_pp4);
    chk({tag, ".valid"},  {31'h0, valid},     {31'h0, m_valid});
    chk({tag, ".halted"}, {31'h0, halted},    {31'h0, m_halt});
    chk({tag, ".fault"},  {31'h0, fault},     {31'h0, m_fault});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    redirect = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_all(tag);
    rst_n = 1'b1;
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, compare after the edge.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic st,
                      input logic fl, input string tag);
    logic [31:0] word;
    redirect = rd; redirect_pc = rpc; stall = st; flush = fl;
    if (m_halt) begin
      bubble();
    end else if (rd && (rpc % 4 != 0)) begin
      bubble(); m_fault = 1'b1; m_halt = 1'b1;
    end else if (rd) begin
      bubble(); m_pc = rpc;
    end else if (fl) begin
      bubble();
      if (!st) m_pc = m_pc + 4;
    end else if (st) begin
      // everything holds
    end else if (m_pc / 4 >= 64) begin
      bubble(); m_fault = 1'b1; m_halt = 1'b1;
    end else begin
      word = rom[m_pc / 4];
      if (word == HALTW) begin
        bubble(); m_halt = 1'b1;
      end else begin
        m_instr = word; m_pp4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic fill_rom(input int halt_odds);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == HALTW) w = 32'h1234_5678;
      if (halt_odds != 0 && $urandom_range(0, halt_odds - 1) == 0) w = HALTW;
      rom[i] = w;
    end
  endtask

  initial begin
    logic [31:0] tgt;
    logic [31:0] ra, rb, rc;
    fill_rom(0);
    rom[5] = HALTW;
    ra = rom[0]; rb = rom[1]; rc = rom[2];

    // 1. Reset and free run
    do_reset("reset");
    chk("reset.pc_const", pc, 32'h0);
    step(0, 0, 0, 0, "run0");
    chk("run0.instrA", instr, ra);
    step(0, 0, 0, 0, "run1");
    chk("run1.pp4", pp4, 32'd8);

    // 2. Stall at PC=8
    step(0, 0, 1, 0, "stall0");
    step(0, 0, 1, 0, "stall1");
    chk("stall.pc", pc, 32'd8);
    chk("stall.instrB", instr, rb);
    step(0, 0, 0, 0, "resume");
    chk("resume.instrC", instr, rc);
    chk("resume.pp4", pp4, 32'd12);

    // 3. Redirect overriding stall
    step(1, 32'h20, 1, 0, "redir");
    chk("redir.pc", pc, 32'h20);
    chk("redir.valid", {31'h0, valid}, 32'h0);
    step(0, 0, 0, 0, "redir_next");
    chk("redir_next.pp4", pp4, 32'h24);

    // Flush with and without stall
    step(0, 0, 1, 1, "flush_stall");
    step(0, 0, 0, 1, "flush");

    // 4. Misaligned redirect
    tgt = pc;
    step(1, 32'h22, 0, 0, "misal");
    chk("misal.pc", pc, tgt);
    chk("misal.fault", {31'h0, fault}, 32'h1);
    for (int i = 0; i < 4; i++) step(1'($urandom), 32'h40, 1'($urandom), 1'($urandom), "halt_ign");

    // 5. Halt word at ROM[5]
    do_reset("reset5");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "run5");
    step(0, 0, 0, 0, "hw");
    chk("hw.halted", {31'h0, halted}, 32'h1);
    chk("hw.fault", {31'h0, fault}, 32'h0);
    chk("hw.pc", pc, 32'd20);
    step(0, 0, 0, 0, "hw_after");

    // 6. Run off the end of the ROM, then reset asynchronously in HALT
    rom[5] = 32'h0BAD_F00D;
    do_reset("reset6");
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, "run64");
    chk("end.pc", pc, 32'd256);
    step(0, 0, 0, 0, "oor");
    chk("oor.fault", {31'h0, fault}, 32'h1);
    chk("oor.halted", {31'h0, halted}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized phase
    fill_rom(12);
    do_reset("reset_rand");
    for (int n = 0; n < 400; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset("rand_reset");
      end else begin
        tgt = 4 * $urandom_range(0, 63);
        case ($urandom_range(0, 15))
          0: tgt = tgt | 32'($urandom_range(1, 3));
          1: tgt = 32'h0000_0400 + tgt;
          default: ;
        endcase
        step($urandom_range(0, 9) == 0, tgt, $urandom_range(0, 5) == 0,
             $urandom_range(0, 9) == 0, "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
